// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM arbiter: sequencer states, default
// geometry and the write-strobe levels used by the write phases.
package sram_arb_pkg;

  typedef enum logic [2:0] {
    S_BOOT,
    S_CFG_RD,
    S_CFG_LAT,
    S_READ,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD
  } arb_state_e;

  localparam int unsigned ADDR_W_DEF    = 19;
  localparam int unsigned DATA_W_DEF    = 8;
  localparam logic [18:0] CFG_ADDR_DEF  = 19'h08FD5;
  localparam int unsigned BOOT_WAIT_DEF = 32;
  localparam int unsigned HOLD_TAIL_DEF = 255;

  localparam logic WE_ASSERT = 1'b0;
  localparam logic WE_IDLE   = 1'b1;

endpackage

// File: rtl/sram_hold_timer.sv
// Saturating cycle counter: restart clears it, enable advances it, and
// expired is high once LIMIT enabled cycles have been seen.
module sram_hold_timer #(
  parameter int unsigned LIMIT = 254
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 2);

  logic [CNT_W-1:0] cnt_q;

  assign expired_o = (cnt_q == CNT_W'(LIMIT));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (restart_i) begin
      cnt_q <= '0;
    end else if (enable_i && !expired_o) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Sequences the shared asynchronous SRAM between the boot config read,
// loader writes and pipelined core ROM reads; also drives the core hold.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter int unsigned       DATA_W    = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] CFG_ADDR  = ADDR_W'(CFG_ADDR_DEF),
  parameter int unsigned       BOOT_WAIT = BOOT_WAIT_DEF,
  parameter int unsigned       HOLD_TAIL = HOLD_TAIL_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ldr_req,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_data,
  output logic              ldr_ack,
  input  logic [ADDR_W-1:0] core_addr,
  output logic [DATA_W-1:0] core_data,
  output logic              core_valid,
  output logic [DATA_W-1:0] cfg_data,
  output logic              cfg_valid,
  output logic              core_hold,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_oe,
  input  logic [DATA_W-1:0] sram_din,
  output logic              sram_we_n
);

  arb_state_e        state_q;
  logic [ADDR_W-1:0] sram_addr_q;
  logic [DATA_W-1:0] sram_dout_q;
  logic              sram_oe_q;
  logic              sram_we_n_q;
  logic              ldr_ack_q;
  logic [DATA_W-1:0] core_data_q;
  logic              core_valid_q;
  logic              rd_pend_q;
  logic [DATA_W-1:0] cfg_data_q;
  logic              cfg_valid_q;
  logic              core_hold_q;
  logic              loaded_q;

  logic boot_done;
  logic tail_done;
  logic hold_restart;
  logic hold_count;
  logic hold_release;

  assign hold_restart = ldr_req || (state_q != S_READ);
  assign hold_count   = (state_q == S_READ) && !ldr_req && loaded_q;
  // Release only after at least one completed load and a latched config byte.
  assign hold_release = tail_done && hold_count && cfg_valid_q;

  sram_hold_timer #(
    .LIMIT (BOOT_WAIT - 1)
  ) u_boot_timer (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .restart_i (1'b0),
    .enable_i  (state_q == S_BOOT),
    .expired_o (boot_done)
  );

  sram_hold_timer #(
    .LIMIT (HOLD_TAIL - 1)
  ) u_tail_timer (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .restart_i (hold_restart),
    .enable_i  (hold_count),
    .expired_o (tail_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_BOOT;
      sram_addr_q  <= CFG_ADDR;
      sram_dout_q  <= '0;
      sram_oe_q    <= 1'b0;
      sram_we_n_q  <= WE_IDLE;
      ldr_ack_q    <= 1'b0;
      core_data_q  <= '0;
      core_valid_q <= 1'b0;
      rd_pend_q    <= 1'b0;
      cfg_data_q   <= '0;
      cfg_valid_q  <= 1'b0;
      core_hold_q  <= 1'b1;
      loaded_q     <= 1'b0;
    end else begin
      ldr_ack_q    <= 1'b0;
      rd_pend_q    <= 1'b0;
      // A read issued in the last READ cycle still retires, even when a write starts.
      core_valid_q <= rd_pend_q;
      if (rd_pend_q) begin
        core_data_q <= sram_din;
      end

      if (ldr_req) begin
        core_hold_q <= 1'b1;
      end else if (hold_release) begin
        core_hold_q <= 1'b0;
      end

      unique case (state_q)
        S_BOOT: begin
          sram_addr_q <= CFG_ADDR;
          if (boot_done) begin
            state_q <= S_CFG_RD;
          end
        end
        S_CFG_RD: begin
          sram_addr_q <= CFG_ADDR;
          state_q     <= S_CFG_LAT;
        end
        S_CFG_LAT: begin
          cfg_data_q  <= sram_din;
          cfg_valid_q <= 1'b1;
          state_q     <= S_READ;
        end
        S_READ: begin
          if (ldr_req) begin
            sram_addr_q <= ldr_addr;
            sram_dout_q <= ldr_data;
            sram_oe_q   <= 1'b1;
            sram_we_n_q <= WE_IDLE;
            state_q     <= S_WR_SETUP;
          end else begin
            sram_addr_q <= core_addr;
            rd_pend_q   <= 1'b1;
          end
        end
        S_WR_SETUP: begin
          sram_we_n_q <= WE_ASSERT;
          state_q     <= S_WR_PULSE;
        end
        S_WR_PULSE: begin
          sram_we_n_q <= WE_IDLE;
          ldr_ack_q   <= 1'b1;
          loaded_q    <= 1'b1;
          state_q     <= S_WR_HOLD;
        end
        S_WR_HOLD: begin
          sram_oe_q <= 1'b0;
          state_q   <= S_READ;
        end
        default: begin
          state_q <= S_BOOT;
        end
      endcase
    end
  end

  assign sram_addr  = sram_addr_q;
  assign sram_dout  = sram_dout_q;
  assign sram_oe    = sram_oe_q;
  assign sram_we_n  = sram_we_n_q;
  assign ldr_ack    = ldr_ack_q;
  assign core_data  = core_data_q;
  assign core_valid = core_valid_q;
  assign cfg_data   = cfg_data_q;
  assign cfg_valid  = cfg_valid_q;
  assign core_hold  = core_hold_q;

endmodule
